// File: rtl/fetch_pkg.sv
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    localparam int          IMEM_AWIDTH = 12;
    localparam logic [31:0] IMEM_LIMIT  = 32'h0000_4000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // A fetch PC is usable only if word aligned and inside the 16 KiB memory.
    function automatic logic pc_in_range(input logic [31:0] pc);
        return (pc[1:0] == 2'b00) && (pc < IMEM_LIMIT);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module      : fetch_queue
// Description : DEPTH-entry synchronous FIFO of fetch entries with flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL  = (c_PTR_W + 1)'(DEPTH);

    fetch_entry_t         r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W:0]     r_count;

    // Storage is cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= push_entry;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                r_count <= r_count + 1'b1;
            end else if (pop && !push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign full  = (r_count == c_FULL);
    assign empty = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : Sequential instruction fetch with redirect, range fault and
//               an instruction queue. Optional counters under FETCH_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic [IMEM_AWIDTH-1:0] imem_addr,
    output logic                   imem_en,
    input  logic [31:0]            imem_data,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    output logic                   inst_valid,
    input  logic                   inst_ready,
    output logic [31:0]            inst,
    output logic [31:0]            inst_pc,
    output logic                   fault
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]            perf_fetched,
    output logic [31:0]            perf_stall
`endif
);

    fetch_state_t r_state;
    logic [31:0]  r_fetch_pc;
    fetch_entry_t w_head;
    fetch_entry_t w_push_entry;
    logic         w_full;
    logic         w_empty;
    logic         w_pop;
    logic         w_in_range;
    logic         w_fetch;

    // Redirect suppresses both push and pop in its cycle.
    assign w_in_range   = pc_in_range(r_fetch_pc);
    assign w_pop        = !w_empty && inst_ready && !redirect;
    assign w_fetch      = (r_state == FETCH) && !redirect && w_in_range && (!w_full || w_pop);
    assign w_push_entry = '{pc: r_fetch_pc, inst: imem_data};

    assign imem_en    = w_fetch;
    assign imem_addr  = r_fetch_pc[IMEM_AWIDTH+1:2];
    assign inst_valid = !w_empty;
    assign inst       = w_head.inst;
    assign inst_pc    = w_head.pc;
    assign fault      = (r_state == FAULT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= FETCH;
            r_fetch_pc <= RESET_PC;
        end else if (redirect) begin
            r_state    <= FETCH;
            r_fetch_pc <= redirect_pc;
        end else if ((r_state == FETCH) && !w_in_range) begin
            r_state    <= FAULT;
        end else if (w_fetch) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clock      (clock),
        .reset      (reset),
        .push       (w_fetch),
        .push_entry (w_push_entry),
        .pop        (w_pop),
        .flush      (redirect),
        .head       (w_head),
        .full       (w_full),
        .empty      (w_empty)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_pop && (r_perf_fetched != '1)) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if ((r_state == FETCH) && w_full && !w_pop && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit (queue-level model plus
//               directed literal checks).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_ready;
    logic [11:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fault;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    logic [31:0] imem [4096];
    assign imem_data = imem[imem_addr];

    always #5 clock = ~clock;

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .imem_addr    (imem_addr),
        .imem_en      (imem_en),
        .imem_data    (imem_data),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .inst         (inst),
        .inst_pc      (inst_pc),
        .fault        (fault)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    endtask

    // Model: queue of {pc, inst} entries, next fetch PC and fault flag.
    logic [63:0] m_q [$];
    logic [31:0] m_pc    = RESET_PC;
    logic        m_fault = 1'b0;

    function automatic logic exp_en();
        return !m_fault && !redirect && (m_pc[1:0] == 2'b00) && (m_pc < 32'h0000_4000)
            && ((m_q.size() < DEPTH) || ((m_q.size() != 0) && inst_ready));
    endfunction

    initial begin
        logic pop_now;
        logic en_now;
        forever begin
            @(negedge clock);
            if (reset) begin
                check("rst_valid", {31'b0, inst_valid}, 32'd0);
                check("rst_fault", {31'b0, fault}, 32'd0);
                check("rst_inst", inst, 32'd0);
                check("rst_inst_pc", inst_pc, 32'd0);
            end else begin
                check("valid", {31'b0, inst_valid}, {31'b0, (m_q.size() != 0)});
                check("fault", {31'b0, fault}, {31'b0, m_fault});
                if (m_q.size() != 0) begin
                    check("inst", inst, m_q[0][31:0]);
                    check("inst_pc", inst_pc, m_q[0][63:32]);
                end
                check("imem_en", {31'b0, imem_en}, {31'b0, exp_en()});
                if (exp_en()) check("imem_addr", {20'b0, imem_addr}, {20'b0, m_pc[13:2]});
            end
            @(posedge clock);
            if (reset) begin
                m_q.delete();
                m_pc    = RESET_PC;
                m_fault = 1'b0;
            end else begin
                en_now  = exp_en();
                pop_now = (m_q.size() != 0) && inst_ready && !redirect;
                if (redirect) begin
                    m_q.delete();
                    m_pc    = redirect_pc;
                    m_fault = 1'b0;
                end else begin
                    if (pop_now) void'(m_q.pop_front());
                    if (!m_fault && !((m_pc[1:0] == 2'b00) && (m_pc < 32'h0000_4000))) begin
                        m_fault = 1'b1;
                    end else if (en_now) begin
                        m_q.push_back({m_pc, imem[m_pc[13:2]]});
                        m_pc = m_pc + 32'd4;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        tick();
        redirect    = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 4096; k++) imem[k] = 32'hA000_0000 + k;
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        inst_ready  = 1'b0;
        repeat (3) tick();
        check("lit_rst_valid", {31'b0, inst_valid}, 32'd0);
        check("lit_rst_inst", inst, 32'd0);

        // Streaming from reset, one instruction per cycle.
        reset      = 1'b0;
        inst_ready = 1'b1;
        tick();
        check("lit_c1_pc", inst_pc, 32'h0);
        check("lit_c1_inst", inst, 32'hA000_0000);
        tick();
        check("lit_c2_pc", inst_pc, 32'h4);
        check("lit_c2_inst", inst, 32'hA000_0001);
        repeat (4) tick();
        check("lit_c6_pc", inst_pc, 32'h14);

        // Back-pressure: queue fills, fetch stops, head held.
        inst_ready = 1'b0;
        repeat (5) tick();
        check("lit_full_en", {31'b0, imem_en}, 32'd0);
        check("lit_held_pc", inst_pc, 32'h14);
        check("lit_held_inst", inst, 32'hA000_0005);
        inst_ready = 1'b1;
        tick();
        check("lit_drain_pc", inst_pc, 32'h18);

        // Redirect while full.
        inst_ready = 1'b0;
        repeat (3) tick();
        do_redirect(32'h100);
        inst_ready = 1'b1;
        check("lit_redir_flush", {31'b0, inst_valid}, 32'd0);
        tick();
        check("lit_redir_pc", inst_pc, 32'h100);
        check("lit_redir_inst", inst, 32'hA000_0040);
        repeat (3) tick();

        // End of memory: last two words delivered, then fault.
        do_redirect(32'h3FF8);
        tick();
        check("lit_end_pc0", inst_pc, 32'h3FF8);
        check("lit_end_inst0", inst, 32'hA000_0FFE);
        tick();
        check("lit_end_pc1", inst_pc, 32'h3FFC);
        check("lit_end_inst1", inst, 32'hA000_0FFF);
        check("lit_end_en", {31'b0, imem_en}, 32'd0);
        tick();
        check("lit_end_fault", {31'b0, fault}, 32'd1);
        check("lit_end_valid", {31'b0, inst_valid}, 32'd0);
        repeat (2) tick();
        check("lit_fault_en", {31'b0, imem_en}, 32'd0);
        do_redirect(32'h0);
        check("lit_clr_fault", {31'b0, fault}, 32'd0);
        tick();
        check("lit_clr_inst", inst, 32'hA000_0000);

        // Misaligned redirect.
        do_redirect(32'h102);
        check("lit_mis_en", {31'b0, imem_en}, 32'd0);
        tick();
        check("lit_mis_fault", {31'b0, fault}, 32'd1);
        check("lit_mis_valid", {31'b0, inst_valid}, 32'd0);

        // Fault with a full queue, then asynchronous reset.
        inst_ready = 1'b0;
        do_redirect(32'h3FF8);
        repeat (3) tick();
        check("lit_fq_fault", {31'b0, fault}, 32'd1);
        check("lit_fq_pc", inst_pc, 32'h3FF8);
        inst_ready = 1'b1;
        tick();
        check("lit_fq_drain", inst_pc, 32'h3FFC);
        inst_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("lit_arst_valid", {31'b0, inst_valid}, 32'd0);
        check("lit_arst_fault", {31'b0, fault}, 32'd0);
        check("lit_arst_pc", inst_pc, 32'd0);
        repeat (2) tick();

`ifdef FETCH_PERF_EN
        reset = 1'b0;
        repeat (DEPTH + 3) tick();
        inst_ready = 1'b1;
        repeat (10) tick();
        check("perf_fetched", perf_fetched, 32'd10);
        check("perf_stall", perf_stall, 32'd3);
`endif

        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, byte address of the first fetch after reset.
REQ-002 Parameter DEPTH, default 2, instruction queue entries (legal: 2 or 4).
REQ-003 clock  input  1  sole clock; all state changes on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 imem_addr  output  12  word address to the 4096x32 instruction memory, equal to fetch_pc[13:2].
REQ-006 imem_en  output  1  high when a fetch is sampled this cycle.
REQ-007 imem_data  input  32  combinational read data for imem_addr, valid in the same cycle.
REQ-008 redirect  input  1  flush and restart fetch at redirect_pc.
REQ-009 redirect_pc  input  32  new byte PC, sampled when redirect is high.
REQ-010 inst_valid  output  1  queue head holds a valid instruction.
REQ-011 inst_ready  input  1  consumer accepts the head this cycle.
REQ-012 inst  output  32  head instruction word.
REQ-013 inst_pc  output  32  byte PC of the head instruction.
REQ-014 fault  output  1  high while in state FAULT.

Function
REQ-015 States: FETCH and FAULT; fault = (state == FAULT).
REQ-016 Fetch condition: state == FETCH, redirect low, and the queue is not full or a pop occurs this cycle.
REQ-017 When the fetch condition holds, imem_en = 1 and at posedge {fetch_pc, imem_data} is pushed and fetch_pc increments by 4.
REQ-018 Pop: inst_valid && inst_ready pops the head at posedge; push and pop in the same cycle keep the count unchanged.
REQ-019 Latency: an instruction fetched in cycle N is visible at the head in cycle N+1 if the queue was empty.
REQ-020 Redirect (highest priority):
  - at posedge, all queue entries are flushed (inst_valid = 0 next cycle);
  - fetch_pc is set to redirect_pc;
  - state goes to FETCH;
  - no push and no pop occur that cycle.
REQ-021 Range check: if fetch_pc[1:0] != 0 or fetch_pc[31:14] != 0 while in FETCH, there is no push and state goes to FAULT at posedge.
REQ-022 FAULT:
  - no fetches and imem_en = 0;
  - queued entries still drain normally;
  - only redirect leaves the state.
REQ-023 Wrap-around: fetch at 0x0000_3FFC is pushed normally; the next fetch_pc 0x0000_4000 triggers FAULT; there is no silent wrap to address 0.
REQ-024 inst and inst_pc hold their values while inst_valid && !inst_ready (no change without a pop).
REQ-025 imem_en = 0 whenever the queue is full and inst_ready is low.

Reset
REQ-026 While reset is high:
  - fetch_pc = RESET_PC and state = FETCH;
  - queue is empty, inst_valid = 0 and fault = 0;
  - inst and inst_pc = 0.
REQ-027 First fetch occurs in the first cycle after reset deasserts; inst_valid rises at the following posedge.
REQ-028 Reset asserted mid-operation discards all queued entries immediately (asynchronously).

Configuration
REQ-029 Macro FETCH_PERF_EN.
  - Defined: adds output perf_fetched (32-bit), counting pops, and perf_stall (32-bit), counting cycles with state == FETCH and the queue full with no pop. Both saturate at all-ones and clear on reset.
  - Undefined: these ports and counters are absent; all other behaviour is identical.

Structure
REQ-030 Package fetch_pkg holds:
  - the fetch_state_t enum {FETCH, FAULT};
  - constant IMEM_AWIDTH = 12;
  - constant IMEM_LIMIT = 32'h0000_4000;
  - the fetch_entry_t struct {pc[31:0], inst[31:0]}.
REQ-031 Sub-module fetch_queue implements the DEPTH-entry synchronous FIFO of fetch_entry_t, with push, pop, flush, full and empty signals.

Verification
REQ-032 Reset with RESET_PC=0, memory word k = 32'hA000_0000+k, inst_ready=1 -> cycle 1 onward inst_pc = 0, 4, 8…, inst = A000_0000, A000_0001…, one per cycle.
REQ-033 inst_ready=0 for 5 cycles -> exactly DEPTH entries queued, imem_en=0 once full, head held stable; on inst_ready=1, drain resumes in order with no loss or duplicate.
REQ-034 Redirect to 0x100 while queue full -> next cycle inst_valid=0; following cycle inst_pc=0x100, inst = word 0x40.
REQ-035 Redirect to 0x3FF8 -> 0x3FF8 and 0x3FFC delivered, then fault=1, imem_en=0; a later redirect to 0x0 clears fault and fetches word 0.
REQ-036 Redirect to 0x102 (misaligned) -> fault=1 next cycle with no push; reset asserted mid-stream -> inst_valid=0 and fault=0 immediately.
REQ-037 With FETCH_PERF_EN defined, 10 pops and 3 full-stall cycles -> perf_fetched=10 and perf_stall=3.
